// File: rtl/conv2x2_sched.sv
// 2x2 convolution scheduler: loads 4 weight bytes and 4 input bytes over one stream,
// then runs a 4-cycle single-multiplier MAC and presents the sum through a ready/valid handshake.
module conv2x2_sched #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_is_wt,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_seq,
    output logic              wt_loaded,
    output logic              busy
);

    typedef enum logic [1:0] {LOAD = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [1:0]          cnt;
    logic                grp_wt;
    logic [DATA_W-1:0]   w [4];
    logic [DATA_W-1:0]   x [4];
    logic [ACC_W-1:0]    acc;
    logic                seq;
    logic                wt_ok;
    logic                xfer;
    logic                is_wt;
    logic                last;
    logic [2*DATA_W-1:0] prod;

    assign xfer  = in_valid && in_ready;
    assign is_wt = (cnt == 2'd0) ? in_is_wt : grp_wt;
    assign last  = (cnt == 2'd3);
    // cnt is 0 on MAC entry, so it doubles as the tap index and wraps back to 0 on exit
    assign prod  = {{DATA_W{1'b0}}, x[cnt]} * {{DATA_W{1'b0}}, w[cnt]};

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (xfer && last && !is_wt) state_nxt = MAC;
            MAC:     if (last) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == OUT);
        busy      = (state == MAC) || (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 2'd0;
            grp_wt <= 1'b0;
            acc    <= '0;
            seq    <= 1'b0;
            wt_ok  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                w[i] <= '0;
                x[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: if (xfer) begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) grp_wt <= in_is_wt;
                    if (is_wt) w[cnt] <= in_data;
                    else       x[cnt] <= in_data;
                    if (last && is_wt)  wt_ok <= 1'b1;
                    if (last && !is_wt) acc <= '0;
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-2*DATA_W){1'b0}}, prod};
                    cnt <= cnt + 2'd1;
                end
                OUT: if (out_ready) seq <= ~seq;
                default: ;
            endcase
        end
    end

    assign out_data  = acc;
    assign out_seq   = seq;
    assign wt_loaded = wt_ok;

endmodule

// File: doc/conv2x2_sched.md
CONV2X2_SCHED -- requirements
Module: conv2x2_sched

Interface
Parameters:
REQ-001 SHALL have parameter DATA_W, default 8: width of each weight and input byte.
REQ-002 SHALL have parameter ACC_W, default 18: accumulator and result width; must satisfy ACC_W >= 2*DATA_W+2.

Ports:
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, DATA_W: byte stream carrying weight or input-window bytes.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_is_wt, input, 1: the current group is a weight group (1) or an input-window group (0).
REQ-008 SHALL have port in_ready, output, 1: the block accepts a byte this cycle.
REQ-009 SHALL have port out_data, output, ACC_W: convolution result.
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-012 SHALL have port out_seq, output, 1: result parity; toggles after each accepted result.
REQ-013 SHALL have port wt_loaded, output, 1: a complete 4-byte weight set has been loaded since reset.
REQ-014 SHALL have port busy, output, 1: the state is MAC or OUT.

Function
REQ-015 SHALL implement FSM states LOAD, MAC and OUT.
REQ-016 SHALL assert in_ready only in LOAD; a byte transfers when in_valid && in_ready.
REQ-017 SHALL latch the group type from in_is_wt on the first byte of a group (byte count 0) and ignore in_is_wt on bytes 1-3 of that group.
REQ-018 SHALL use a 2-bit byte counter that increments per transfer, wraps 3->0, and stores the byte at tap index = count, with tap 0 as the first byte.
REQ-019 SHALL, on the 4th byte of a weight group, write w[3], set wt_loaded=1 and remain in LOAD.
REQ-020 SHALL, on the 4th byte of an input group, write x[3], clear the accumulator and go to MAC on the next cycle.
REQ-021 SHALL, in MAC, use exactly one DATA_W x DATA_W multiplier: acc += x[k]*w[k] for k=0..3, one tap per cycle (4 cycles), then go to OUT.
REQ-022 SHALL compute all products and sums unsigned, with no overflow: the maximum 4*255*255=260100 fits in 18 bits.
REQ-023 SHALL, in OUT, hold out_valid=1 and out_data=acc stable until out_ready; on the handshake cycle it toggles out_seq and returns to LOAD.
REQ-024 SHALL meet this latency: last input byte accepted at cycle T, MAC occupies T+1..T+4, out_valid=1 from T+5; with out_ready held high, in_ready=1 again at T+6.
REQ-025 SHALL keep weights across windows; a new weight group may arrive between any two windows and affects only later windows.
REQ-026 SHALL use zero weights for a window processed with wt_loaded=0, producing result 0; this is not an error.
REQ-027 SHALL keep out_valid low outside OUT and SHALL NOT change out_data while out_valid=1.
REQ-028 SHALL hold the byte counter and stored bytes while in_valid=0 mid-group; there is no timeout.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state=LOAD, byte count=0, all w and x=0, acc=0, out_valid=0, out_data=0, out_seq=0, wt_loaded=0, busy=0.
REQ-030 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-031 SHALL abort any partial group, MAC or pending output on reset mid-operation, with no output produced.

Verification
REQ-032 SHALL pass: weights 1,2,3,4 (is_wt=1), then inputs 5,6,7,8 (is_wt=0) -> out_data=70, out_valid at T+5, out_seq=0 during the result and 1 after the handshake.
REQ-033 SHALL pass: all weights and inputs 255 -> out_data=260100, no wrap.
REQ-034 SHALL pass: out_ready low for 10 cycles in OUT -> out_valid and out_data stable, in_ready=0, busy=1 throughout.
REQ-035 SHALL pass: inputs 9,9,9,9 sent with no weights loaded -> out_data=0, wt_loaded=0.
REQ-036 SHALL pass: after result 70, reload weights 0,0,0,1 and send inputs 5,6,7,8 -> out_data=8; in_is_wt toggled on bytes 1-3 of a group has no effect.
REQ-037 SHALL pass: rst pulsed in the 2nd MAC cycle -> no out_valid, all outputs at reset values, and the next window with weights 1,1,1,1 and inputs 1,2,3,4 -> 10.
